// File: rtl/axi_rom_rd_responder.sv
// AXI4 read responder in front of a word-wide, 1-cycle-latency synchronous memory.
// One burst at a time; FIXED/INCR/WRAP addressing with OKAY/SLVERR/DECERR per beat.
module axi_rom_rd_responder #(
    parameter logic [31:0] BaseAddr = 32'h0000_0000,
    parameter int          MemBytes = 65536,
    parameter int          IdWidth  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IdWidth-1:0]            arid,
    input  logic [31:0]                   araddr,
    input  logic [7:0]                    arlen,
    input  logic [2:0]                    arsize,
    input  logic [1:0]                    arburst,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [IdWidth-1:0]            rid,
    output logic [31:0]                   rdata,
    output logic [1:0]                    rresp,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rready,
    output logic                          mem_req,
    output logic [$clog2(MemBytes)-3:0]   mem_addr,
    input  logic [31:0]                   mem_rdata
);

    localparam int          AW       = $clog2(MemBytes) - 2;
    localparam logic [31:0] MemLimit = MemBytes;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RESP
    } state_t;

    state_t               r_state;
    logic                 r_arready;
    logic [IdWidth-1:0]   r_rid;
    logic [31:0]          r_addr;
    logic [7:0]           r_len;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic                 r_slverr;
    logic [7:0]           r_cnt;
    logic                 r_ok;
    logic                 r_hold;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;
    logic                 r_rlast;
    logic                 r_rvalid;

    logic [31:0]          w_ar_bytes;
    logic                 w_ar_wrap_len_ok;
    logic                 w_ar_slverr;
    logic [31:0]          w_bytes;
    logic [31:0]          w_span;
    logic [31:0]          w_off;
    logic                 w_inrange;
    logic                 w_beat_ok;
    logic [31:0]          w_next_addr;
    logic [31:0]          w_mem_data;

    // Burst-wide legality is decided once, at capture time.
    assign w_ar_bytes       = 32'd1 << arsize;
    assign w_ar_wrap_len_ok = (arlen == 8'd1) || (arlen == 8'd3) ||
                              (arlen == 8'd7) || (arlen == 8'd15);
    assign w_ar_slverr      = (arsize > 3'd2) || (arburst == BurstRsvd) ||
                              ((arburst == BurstWrap) &&
                               (!w_ar_wrap_len_ok ||
                                ((araddr & (w_ar_bytes - 32'd1)) != 32'd0)));

    assign w_bytes    = 32'd1 << r_size;
    assign w_span     = (32'(r_len) + 32'd1) << r_size;
    assign w_off      = r_addr - BaseAddr;
    assign w_inrange  = w_off < MemLimit;
    assign w_beat_ok  = !r_slverr && w_inrange;
    assign w_mem_data = r_ok ? mem_rdata : 32'd0;

    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            BurstIncr: w_next_addr = (r_addr & ~(w_bytes - 32'd1)) + w_bytes;
            BurstWrap: w_next_addr = (r_addr & ~(w_span - 32'd1)) |
                                     ((r_addr + w_bytes) & (w_span - 32'd1));
            BurstFixed: w_next_addr = r_addr;
            default:   w_next_addr = r_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_rid     <= '0;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_size    <= 3'd0;
            r_burst   <= 2'b00;
            r_slverr  <= 1'b0;
            r_cnt     <= 8'd0;
            r_ok      <= 1'b0;
            r_hold    <= 1'b1;
            r_rdata   <= 32'd0;
            r_rresp   <= RespOkay;
            r_rlast   <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_arready <= 1'b1;
                    if (arvalid && r_arready) begin
                        r_arready <= 1'b0;
                        r_rid     <= arid;
                        r_addr    <= araddr;
                        r_len     <= arlen;
                        r_size    <= arsize;
                        r_burst   <= arburst;
                        r_slverr  <= w_ar_slverr;
                        r_cnt     <= 8'd0;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    r_ok     <= w_beat_ok;
                    r_rresp  <= r_slverr  ? RespSlvErr :
                                w_inrange ? RespOkay : RespDecErr;
                    r_rlast  <= (r_cnt == r_len);
                    r_rvalid <= 1'b1;
                    r_hold   <= 1'b0;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    // Memory data is live only in the first RESP cycle; latch it there.
                    if (!r_hold) begin
                        r_rdata <= w_mem_data;
                        r_hold  <= 1'b1;
                    end
                    if (rready) begin
                        r_rvalid <= 1'b0;
                        if (r_rlast) begin
                            r_state   <= S_IDLE;
                            r_arready <= 1'b1;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign arready  = r_arready;
    assign rid      = r_rid;
    assign rdata    = r_hold ? r_rdata : w_mem_data;
    assign rresp    = r_rresp;
    assign rlast    = r_rlast;
    assign rvalid   = r_rvalid;
    assign mem_req  = (r_state == S_READ) && w_beat_ok;
    assign mem_addr = w_off[AW+1:2];

endmodule

// File: tb/tb_axi_rom_rd_responder.sv
// Bench for axi_rom_rd_responder: directed bursts plus randomized bursts
// checked against a per-beat address/response model and a hashed ROM image.
module tb_axi_rom_rd_responder;

    localparam logic [31:0] Base  = 32'h0001_0000;
    localparam int          MemB  = 65536;
    localparam int          IdW   = 2;
    localparam int          AW    = $clog2(MemB) - 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [IdW-1:0]    arid = '0;
    logic [31:0]       araddr = 32'd0;
    logic [7:0]        arlen = 8'd0;
    logic [2:0]        arsize = 3'd0;
    logic [1:0]        arburst = 2'b00;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [IdW-1:0]    rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b0;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_rdata = 32'd0;

    int nvec = 0;
    int nerr = 0;
    int n_req = 0;

    axi_rom_rd_responder #(
        .BaseAddr (Base),
        .MemBytes (MemB),
        .IdWidth  (IdW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] idx);
        return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous ROM: data appears the cycle after the request.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= romf(32'(mem_addr));
    end

    always @(negedge clk) begin
        if (rst_n && mem_req) n_req++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_arready();
        int t = 0;
        while (!arready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!arready) check("arready_timeout", 0, 1);
    endtask

    task automatic wait_rvalid();
        int t = 0;
        while (!rvalid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rvalid) check("rvalid_timeout", 0, 1);
    endtask

    task automatic run_burst(input logic [IdW-1:0] id, input logic [31:0] a,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int stall_beat,
                             input int stall_cyc, input bit rnd);
        logic [31:0] b;
        logic [31:0] w;
        logic [31:0] wb;
        logic [31:0] ba;
        logic        slv;
        logic        len_ok;
        logic [31:0] ed[256];
        logic [1:0]  er[256];
        int          exp_req;
        int          req0;
        int          k;
        logic [31:0] hd;

        b      = 32'd1 << size;
        w      = (32'(len) + 32'd1) * b;
        len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        slv    = (size > 3'd2) || (burst == 2'b11) ||
                 ((burst == 2'b10) && (!len_ok || (a % b) != 0));
        exp_req = 0;
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b01: ba = (i == 0) ? a : (a & ~(b - 1)) + 32'(i) * b;
                2'b10: begin
                    wb = a - (a % w);
                    ba = wb + (((a - wb) + 32'(i) * b) % w);
                end
                default: ba = a;
            endcase
            if (slv) er[i] = 2'b10;
            else if ((ba - Base) >= 32'(MemB)) er[i] = 2'b11;
            else er[i] = 2'b00;
            ed[i] = (er[i] == 2'b00) ? romf((ba - Base) >> 2) : 32'd0;
            if (er[i] == 2'b00) exp_req++;
        end

        req0    = n_req;
        arid    = id;
        araddr  = a;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        wait_arready();
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("lat_rvalid_n1", rvalid, 0);
        check("lat_memreq_n1", mem_req, er[0] == 2'b00);
        @(posedge clk); #1;
        check("lat_rvalid_n2", rvalid, 1);

        for (int i = 0; i <= int'(len); i++) begin
            wait_rvalid();
            check("rid", rid, id);
            check("rdata", rdata, ed[i]);
            check("rresp", rresp, er[i]);
            check("rlast", rlast, i == int'(len));
            k  = rnd ? $urandom_range(0, 2) : ((i == stall_beat) ? stall_cyc : 0);
            hd = rdata;
            for (int c = 0; c < k; c++) begin
                @(posedge clk); #1;
                check("hold_rvalid", rvalid, 1);
                check("hold_rdata", rdata, hd);
                check("hold_rid", rid, id);
                check("hold_rlast", rlast, i == int'(len));
                check("hold_arready", arready, 0);
            end
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
        check("mem_req_count", n_req - req0, exp_req);
        check("arready_after", arready, 1);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] b;

        #3;
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_req", mem_req, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arready_post_rst", arready, 1);

        run_burst(2'd1, Base + 32'h10, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
        run_burst(2'd2, Base + 32'h18, 8'd3, 3'd2, 2'b10, -1, 0, 1'b0);
        run_burst(2'd3, Base + 32'h20, 8'd1, 3'd2, 2'b01, 1, 5, 1'b0);
        run_burst(2'd0, Base + 32'(MemB) - 32'd4, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0);
        run_burst(2'd1, Base + 32'h40, 8'd2, 3'd3, 2'b01, -1, 0, 1'b0);
        run_burst(2'd2, Base + 32'h40, 8'd2, 3'd2, 2'b11, -1, 0, 1'b0);
        run_burst(2'd3, Base + 32'h13, 8'd2, 3'd2, 2'b01, -1, 0, 1'b0);
        run_burst(2'd0, Base + 32'h16, 8'd2, 3'd2, 2'b10, -1, 0, 1'b0);
        run_burst(2'd1, Base - 32'd8, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0);
        run_burst(2'd2, Base + 32'h31, 8'd2, 3'd0, 2'b00, -1, 0, 1'b0);

        // Reset in the middle of beat 1 of a 4-beat burst.
        arid = 2'd1; araddr = Base; arlen = 8'd3;
        arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        wait_arready();
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_rvalid();
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        wait_rvalid();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rvalid", rvalid, 0);
        check("async_rst_arready", arready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arready_after_rst", arready, 1);
        check("no_beat_after_rst", rvalid, 0);
        run_burst(2'd2, Base + 32'h80, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            burst = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (burst == 2'b10 && $urandom_range(0, 3) != 0)
                len = 8'((2 << $urandom_range(0, 3)) - 1);
            else
                len = 8'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                4:       a = Base + 32'(MemB) - 32'($urandom_range(1, 64));
                5:       a = Base - 32'($urandom_range(1, 64));
                default: a = Base + 32'($urandom_range(0, MemB - 1));
            endcase
            b = 32'd1 << size;
            if (burst == 2'b10 && $urandom_range(0, 3) != 0) a = a & ~(b - 1);
            run_burst(2'($urandom_range(0, 3)), a, len, size, burst, -1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
